// File: rtl/hba_arbiter_if.sv
// HBA arbiter bus bundle: per-master request/bus inputs, shared bus outputs,
// grant vector and watchdog pulse. The arbiter uses the slave modport, the
// masters (or a test environment) use the master modport.
interface hba_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int DBUS_WIDTH  = 8
);
  logic [NUM_MASTERS-1:0]            master_request;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus;
  logic [NUM_MASTERS-1:0]            master_rnw;
  logic [NUM_MASTERS-1:0]            master_select;
  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus;
  logic                              hba_xferack;
  logic [NUM_MASTERS-1:0]            hba_mgrant;
  logic [ADDR_WIDTH-1:0]             hba_abus;
  logic                              hba_rnw;
  logic                              hba_select;
  logic [DBUS_WIDTH-1:0]             hba_dbus;
  logic                              arb_timeout;

  modport slave (
    input  master_request, master_abus, master_rnw, master_select, master_dbus,
    input  hba_xferack,
    output hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus, arb_timeout
  );

  modport master (
    output master_request, master_abus, master_rnw, master_select, master_dbus,
    output hba_xferack,
    input  hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus, arb_timeout
  );
endinterface

// File: rtl/hba_arbiter.sv
// Round-robin arbiter and bus multiplexer for the shared HBA bus.
// Grants are registered and one-hot; ownership is held until the owner drops
// its request. A watchdog revokes the grant of a master whose transfer is
// never acknowledged and keeps it out until it drops its request.
module hba_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 12,
  parameter int DBUS_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          hba_clk,
  input  logic          hba_reset,
  hba_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Index to one-hot conversion for grant and block masks.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_MASTERS'(1) << idx;
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_owner, w_owner_nxt;
  logic [IDX_W-1:0]        r_last, w_last_nxt;
  logic [NUM_MASTERS-1:0]  r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0]  r_blocked, w_blocked_nxt, w_block_set;
  logic [WD_W-1:0]         r_wd, w_wd_nxt;
  logic                    r_timeout, w_timeout_nxt;

  logic [NUM_MASTERS-1:0]  w_eligible;
  logic [IDX_W-1:0]        w_winner, w_scan;
  logic                    w_found, w_hit;
  logic                    w_stall, w_expire, w_owner_req;

  logic [ADDR_WIDTH-1:0]   w_abus;
  logic [DBUS_WIDTH-1:0]   w_dbus;
  logic                    w_rnw, w_select;

  assign w_eligible  = bus.master_request & ~r_blocked;
  assign w_owner_req = bus.master_request[r_owner];
  assign w_stall     = (r_state == ST_OWNED) & w_select & ~bus.hba_xferack;
  assign w_expire    = w_stall & (r_wd == WD_LAST);

  // Round-robin search: first eligible index after the last owner, wrapping.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_scan   = r_last;
    w_hit    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_scan   = (w_scan == IDX_MAX) ? {IDX_W{1'b0}} : w_scan + 1'b1;
      w_hit    = ~w_found & w_eligible[w_scan];
      w_winner = w_hit ? w_scan : w_winner;
      w_found  = w_found | w_hit;
    end
  end

  // Shared bus: AND-OR of every master's signals gated by its grant bit.
  always_comb begin
    w_abus   = {ADDR_WIDTH{1'b0}};
    w_dbus   = {DBUS_WIDTH{1'b0}};
    w_rnw    = 1'b0;
    w_select = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_abus   = w_abus | (bus.master_abus[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}});
      w_dbus   = w_dbus | (bus.master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{r_grant[i]}});
      w_rnw    = w_rnw    | (bus.master_rnw[i]    & r_grant[i]);
      w_select = w_select | (bus.master_select[i] & r_grant[i]);
    end
  end

  // Next-state and next-grant decision for the ownership FSM and watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_block_set   = {NUM_MASTERS{1'b0}};
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_grant_nxt = onehot(w_winner);
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = {NUM_MASTERS{1'b0}};
        end
      end
      ST_OWNED: begin
        if (w_expire) begin
          // Revoke without handing off; the stalled master is locked out.
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = {NUM_MASTERS{1'b0}};
          w_block_set   = onehot(r_owner);
          w_timeout_nxt = 1'b1;
        end else if (!w_owner_req) begin
          // Releasing owner is ineligible here because its request is low.
          if (w_found) begin
            w_owner_nxt = w_winner;
            w_last_nxt  = w_winner;
            w_grant_nxt = onehot(w_winner);
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = {NUM_MASTERS{1'b0}};
          end
        end else begin
          w_grant_nxt = onehot(r_owner);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NUM_MASTERS{1'b0}};
      end
    endcase
    w_blocked_nxt = (r_blocked | w_block_set) & bus.master_request;
    w_wd_nxt      = w_stall ? r_wd + 1'b1 : {WD_W{1'b0}};
  end

  // State, grant, round-robin pointer, lockout and watchdog registers.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= {IDX_W{1'b0}};
      r_last    <= IDX_MAX;
      r_grant   <= {NUM_MASTERS{1'b0}};
      r_blocked <= {NUM_MASTERS{1'b0}};
      r_wd      <= {WD_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_blocked <= w_blocked_nxt;
      r_wd      <= w_wd_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.hba_mgrant  = r_grant;
  assign bus.hba_abus    = w_abus;
  assign bus.hba_dbus    = w_dbus;
  assign bus.hba_rnw     = w_rnw;
  assign bus.hba_select  = w_select;
  assign bus.arb_timeout = r_timeout;

endmodule
